otter_alu_mdu: RTL and testbench
================================

// Module: otter_alu_mdu
// PURPOSE
//  Width-parametrised, handshaked successor to the Otter single-cycle ALU. It adds the RV32M multiply/divide ops.
//  Base ALU ops finish one cycle after accept. MUL*/DIV*/REM* run on an iterative 1-bit-per-cycle datapath.
//  Sits in the Otter EX stage; the control unit stalls the PC/IR while READY=0 or DONE has not yet arrived.
// PARAMETERS
//  WIDTH    32               operand/result width; even, >=8
//  SHAMT_W  $clog2(WIDTH)    localparam; shift amount = B[SHAMT_W-1:0]
// PORTS
//  CLK     in   1      sole clock, rising edge
//  RST_N   in   1      asynchronous, active-low reset
//  START   in   1      request; accepted on a CLK edge when START&READY
//  FLUSH   in   1      synchronous abort of the op in flight
//  OP      in   5      OP[4]=0: OP[3:0] = legacy ALU_FUN code; OP[4]=1: OP[2:0] = RV32M funct3
//  A       in   WIDTH  operand A (rs1)
//  B       in   WIDTH  operand B (rs2 / imm)
//  READY   out  1      can accept this cycle
//  DONE    out  1      1-cycle pulse: RESULT valid
//  RESULT  out  WIDTH  held stable until the next DONE
//  ILLEGAL out  1      qualified by DONE; op unsupported or undefined
// BEHAVIOUR
//  Reset (async, RST_N=0): state=IDLE, READY=1, DONE=0, RESULT=0, ILLEGAL=0, counter=0.
//  FSM states and transitions:
//   - IDLE: on accept, base op or fast-path div -> RESP; any other M op -> ITER.
//   - ITER: runs WIDTH cycles -> FIX.
//   - FIX: sign-correct, register RESULT -> RESP.
//   - RESP: DONE=1, READY=1; a new accept goes straight to ITER/RESP; otherwise -> IDLE.
//  READY is 1 only in IDLE and RESP. START while busy is ignored and not queued. A/B/OP are latched at accept.
//  Latency (accept in cycle 0):
//   - base op and fast-path div: DONE in cycle 1.
//   - iterative op: DONE in cycle WIDTH+2.
//  Base codes: 0000 ADD, 1000 SUB, 0110 OR, 0111 AND, 0100 XOR, 0101 SRL, 0001 SLL, 1101 SRA,
//   0010 SLT (signed), 0011 SLTU, 1001 copy A. Any other code: RESULT=0, ILLEGAL=1.
//  ADD/SUB wrap modulo 2^WIDTH. SLT/SLTU return 1 or 0, zero-extended.
//  M ops (funct3 0..7):
//   - MUL: low WIDTH bits of the product.
//   - MULH: high half, signed x signed. MULHSU: high half, signed A x unsigned B. MULHU: high half, unsigned.
//   - DIV/DIVU: quotient truncated toward zero. REM/REMU: remainder takes the sign of A.
//  Datapath: operands are converted to unsigned magnitudes, then shift-add multiply (2*WIDTH accumulator)
//   or restoring divide. FIX negates the product/quotient/remainder as the signs require.
//  Fast path (no ITER):
//   - B==0: DIV/DIVU -> all ones; REM/REMU -> A.
//   - DIV with A=100..0, B=all ones -> A; REM with the same operands -> 0.
//   - ILLEGAL=0 in every fast-path case.
//  FLUSH: in ITER/FIX -> IDLE next edge, no DONE, RESULT keeps its old value. FLUSH wins over a same-cycle START.
//  RST_N low mid-op: everything returns to reset values immediately; no DONE for the lost op.
// CONFIGURATION
//  OTTER_ALU_DIV_EN defined: the divider is built; DIV/DIVU/REM/REMU behave as above.
//  Undefined: the divide datapath is removed; any divide op finishes in cycle 1 with RESULT=0, ILLEGAL=1.
//   Multiply is unaffected.
// STRUCTURE
//  otter_alu_pkg: alu_fun_t enum (the 4-bit codes), mdu_fun_t enum (funct3), state_t enum.
//  Sub-module otter_mdu_iter: magnitude shift-add / restoring-divide engine with its own counter,
//   driven by the parent FSM. Base ALU logic stays inline in otter_alu_mdu.
// TESTING (WIDTH=32)
//  1. ADD A=0x7FFFFFFF B=1 -> DONE in cycle 1, RESULT=0x80000000, ILLEGAL=0.
//  2. SRA A=0x80000000 B=0x24 -> RESULT=0xF8000000 (shift 4). OP=5'b01111 -> RESULT=0, ILLEGAL=1.
//  3. MUL and MULH A=B=0xFFFFFFFF -> 1 and 0; MULHU same -> 0xFFFFFFFE; each DONE in cycle 34.
//     START pulses while busy are ignored (exactly one DONE per accepted op).
//  4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, cycle 1. DIVU 5/0 -> 0xFFFFFFFF. REM 7/0 -> 7.
//     REM -7/2 -> 0xFFFFFFFF, cycle 34.
//  5. FLUSH in cycle 10 of a MUL -> no DONE, READY=1 in cycle 11, RESULT unchanged.
//     RST_N low mid-DIVU -> READY=1, RESULT=0 immediately.
//  6. Back-to-back: second START in the DONE cycle is accepted; repeat with OTTER_ALU_DIV_EN undefined:
//     DIV 6/3 -> RESULT=0, ILLEGAL=1, cycle 1.

Source files
------------

// File: rtl/otter_alu_pkg.sv
// rtl/otter_alu_pkg.sv - shared opcode, funct3 and FSM state types for the Otter ALU/MDU
package otter_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_CPYA = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_fun_t;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_fun_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // MUL treats both operands as unsigned: its low half is sign-agnostic.
    function automatic logic signed_a(input logic [2:0] funct);
        return (funct == MDU_MULH) || (funct == MDU_MULHSU) ||
               (funct == MDU_DIV)  || (funct == MDU_REM);
    endfunction

    function automatic logic signed_b(input logic [2:0] funct);
        return (funct == MDU_MULH) || (funct == MDU_DIV) || (funct == MDU_REM);
    endfunction

endpackage

// File: rtl/otter_mdu_iter.sv
// rtl/otter_mdu_iter.sv - 1-bit-per-cycle magnitude multiply / restoring-divide engine
// Divide step exists only when OTTER_ALU_DIV_EN is defined.
module otter_mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   ma_i,
    input  logic [WIDTH-1:0]   mb_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               last_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [WIDTH:0]     mul_sum;

    // Lower half starts as multiplier / dividend; opd holds multiplicand / divisor.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);

`ifdef OTTER_ALU_DIV_EN
    logic           div_q;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    assign rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    assign trial  = rem_sh - {1'b0, opd_q};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q <= 1'b0;
        end else if (load_i) begin
            div_q <= div_i;
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (!div_q) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, ma_i};
        end else if (!step_i) begin
            acc_d = acc_q;
        end
    end
`else
    logic unused_div;
    assign unused_div = div_i;

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, ma_i};
        end else if (step_i) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end
`endif

    always_comb begin
        cnt_d = cnt_q;
        opd_d = opd_q;
        if (load_i) begin
            cnt_d = '0;
            opd_d = mb_i;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            acc_q <= '0;
            opd_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opd_q <= opd_d;
        end
    end

    assign acc_o  = acc_q;
    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/otter_alu_mdu.sv
// rtl/otter_alu_mdu.sv - handshaked Otter ALU with iterative RV32M multiply/divide
// Build option: OTTER_ALU_DIV_EN enables the divider; otherwise divide ops report ILLEGAL.
module otter_alu_mdu
    import otter_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             illegal_o
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               illegal_q, illegal_d;
    logic [2:0]         funct_q, funct_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;

    logic               accept;
    logic               load;
    logic               last;
    logic [2*WIDTH-1:0] acc;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_bad;
    logic [2:0]         funct;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   ma, mb;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_res;

    assign ready_o   = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign done_o    = (state_q == ST_RESP);
    assign result_o  = result_q;
    assign illegal_o = illegal_q;
    assign accept    = start_i && ready_o && !flush_i;
    assign shamt     = b_i[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        alu_bad = 1'b0;
        case (alu_fun_t'(op_i[3:0]))
            ALU_ADD:  alu_res = a_i + b_i;
            ALU_SUB:  alu_res = a_i - b_i;
            ALU_OR:   alu_res = a_i | b_i;
            ALU_AND:  alu_res = a_i & b_i;
            ALU_XOR:  alu_res = a_i ^ b_i;
            ALU_SRL:  alu_res = a_i >> shamt;
            ALU_SLL:  alu_res = a_i << shamt;
            ALU_SRA:  alu_res = $unsigned($signed(a_i) >>> shamt);
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a_i < b_i};
            ALU_CPYA: alu_res = a_i;
            default:  alu_bad = 1'b1;
        endcase
    end

    // The engine only ever sees magnitudes; signs are re-applied in FIX.
    assign funct = op_i[2:0];
    assign neg_a = signed_a(funct) && a_i[WIDTH-1];
    assign neg_b = signed_b(funct) && b_i[WIDTH-1];
    assign ma    = neg_a ? -a_i : a_i;
    assign mb    = neg_b ? -b_i : b_i;

`ifdef OTTER_ALU_DIV_EN
    logic             fast_hit;
    logic [WIDTH-1:0] fast_res;

    // funct[1] selects remainder, funct[0] selects unsigned.
    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
        if (funct[2]) begin
            if (b_i == '0) begin
                fast_hit = 1'b1;
                fast_res = funct[1] ? a_i : '1;
            end else if (!funct[0] && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1)) begin
                fast_hit = 1'b1;
                fast_res = funct[1] ? '0 : a_i;
            end
        end
    end
`endif

    otter_mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (load),
        .step_i  (state_q == ST_ITER),
        .div_i   (funct[2]),
        .ma_i    (ma),
        .mb_i    (mb),
        .acc_o   (acc),
        .last_o  (last)
    );

    assign prod = (neg_a_q ^ neg_b_q) ? -acc : acc;
    assign quo  = (neg_a_q ^ neg_b_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_a_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        case (mdu_fun_t'(funct_q))
            MDU_MUL:                          fix_res = prod[WIDTH-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_res = prod[2*WIDTH-1:WIDTH];
            MDU_DIV, MDU_DIVU:                fix_res = quo;
            default:                          fix_res = rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        funct_d   = funct_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        load      = 1'b0;
        case (state_q)
            ST_ITER: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d  = fix_res;
                    illegal_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (!op_i[4]) begin
                        result_d  = alu_res;
                        illegal_d = alu_bad;
                        state_d   = ST_RESP;
                    end
`ifdef OTTER_ALU_DIV_EN
                    else if (fast_hit) begin
                        result_d  = fast_res;
                        illegal_d = 1'b0;
                        state_d   = ST_RESP;
                    end
`else
                    else if (funct[2]) begin
                        result_d  = '0;
                        illegal_d = 1'b1;
                        state_d   = ST_RESP;
                    end
`endif
                    else begin
                        load    = 1'b1;
                        funct_d = funct;
                        neg_a_d = neg_a;
                        neg_b_d = neg_b;
                        state_d = ST_ITER;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
            funct_q   <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            funct_q   <= funct_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
        end
    end

endmodule

// File: tb/tb_otter_alu_mdu.sv
// tb/tb_otter_alu_mdu.sv - randomized self-checking bench for otter_alu_mdu (WIDTH=32)
module tb_otter_alu_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready, done, illegal;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res;

    otter_alu_mdu #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .flush_i   (flush),
        .op_i      (op),
        .a_i       (a),
        .b_i       (b),
        .ready_o   (ready),
        .done_o    (done),
        .result_o  (result),
        .illegal_o (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {illegal, result} straight from the arithmetic definitions.
    function automatic logic [32:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] pu;
        longint      ps, xs, ys;
        int          sx, sy;
        pu = {32'b0, x} * {32'b0, y};
        xs = longint'($signed(x));
        ys = longint'($signed(y));
        sx = $signed(x);
        sy = $signed(y);
        if (!o[4]) begin
            case (o[3:0])
                4'b0000: return {1'b0, x + y};
                4'b1000: return {1'b0, x - y};
                4'b0110: return {1'b0, x | y};
                4'b0111: return {1'b0, x & y};
                4'b0100: return {1'b0, x ^ y};
                4'b0101: return {1'b0, x >> y[4:0]};
                4'b0001: return {1'b0, x << y[4:0]};
                4'b1101: return {1'b0, 32'($signed(x) >>> y[4:0])};
                4'b0010: return {1'b0, 31'b0, sx < sy};
                4'b0011: return {1'b0, 31'b0, x < y};
                4'b1001: return {1'b0, x};
                default: return {1'b1, 32'b0};
            endcase
        end
        case (o[2:0])
            3'd0: return {1'b0, pu[31:0]};
            3'd1: begin ps = xs * ys; return {1'b0, ps[63:32]}; end
            3'd2: begin ps = xs * longint'({32'b0, y}); return {1'b0, ps[63:32]}; end
            3'd3: return {1'b0, pu[63:32]};
            default: begin
`ifdef OTTER_ALU_DIV_EN
                if (y == 0) return {1'b0, o[1] ? x : 32'hFFFF_FFFF};
                if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return {1'b0, o[1] ? 32'h0 : x};
                case (o[1:0])
                    2'b00: return {1'b0, 32'(sx / sy)};
                    2'b01: return {1'b0, x / y};
                    2'b10: return {1'b0, 32'(sx % sy)};
                    default: return {1'b0, x % y};
                endcase
`else
                return {1'b1, 32'b0};
`endif
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!o[4]) return 1;
        if (o[2]) begin
`ifdef OTTER_ALU_DIV_EN
            if (y == 0) return 1;
            if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`else
            return 1;
`endif
        end
        return 34;
    endfunction

    // Entered at a negedge with ready high; leaves at the negedge of the DONE cycle.
    task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string tag, input bit noise);
        logic [32:0] exp;
        int n;
        exp = model(o, x, y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 60) begin
            if (noise && n >= 2 && n <= 5) begin
                start = 1'b1;
                op = 5'($urandom);
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        last_res = result;
        check({tag, "_lat"}, 64'(n), 64'(model_lat(o, x, y)));
        check({tag, "_res"}, {32'b0, result}, {32'b0, exp[31:0]});
        check({tag, "_ill"}, {63'b0, illegal}, {63'b0, exp[32]});
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_nodone"}, {63'b0, done}, 64'd0);
        check({tag, "_ready"}, {63'b0, ready}, 64'd1);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prev;
        logic [4:0]  rop;
        int          dones;

        #3;
        check("rst_ready", {63'b0, ready}, 64'd1);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_result", {32'b0, result}, 64'd0);
        check("rst_illegal", {63'b0, illegal}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(5'b00000, 32'h7FFF_FFFF, 32'h1, "add_ovf", 0);
        check("add_ovf_const", {32'b0, last_res}, 64'h8000_0000);
        idle_check("add_ovf");
        do_op(5'b01101, 32'h8000_0000, 32'h24, "sra", 0);
        check("sra_const", {32'b0, last_res}, 64'hF800_0000);
        do_op(5'b01111, 32'h1234, 32'h5678, "bad_code", 0);
        check("bad_code_const", {32'b0, last_res}, 64'h0);
        idle_check("bad_code");

        do_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul", 1);
        check("mul_const", {32'b0, last_res}, 64'h1);
        idle_check("mul");
        do_op(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh", 1);
        check("mulh_const", {32'b0, last_res}, 64'h0);
        idle_check("mulh");
        do_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu", 1);
        check("mulhu_const", {32'b0, last_res}, 64'hFFFF_FFFE);
        idle_check("mulhu");

`ifdef OTTER_ALU_DIV_EN
        do_op(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
        check("div_ovf_const", {32'b0, last_res}, 64'h8000_0000);
        do_op(5'b10101, 32'd5, 32'd0, "divu_z", 0);
        check("divu_z_const", {32'b0, last_res}, 64'hFFFF_FFFF);
        do_op(5'b10110, 32'd7, 32'd0, "rem_z", 0);
        check("rem_z_const", {32'b0, last_res}, 64'h7);
        do_op(5'b10110, 32'hFFFF_FFF9, 32'd2, "rem_neg", 1);
        check("rem_neg_const", {32'b0, last_res}, 64'hFFFF_FFFF);
        idle_check("rem_neg");
`else
        do_op(5'b10100, 32'd6, 32'd3, "div_off", 0);
        check("div_off_const", {32'b0, last_res}, 64'h0);
        idle_check("div_off");
`endif

        // FLUSH in cycle 10 of a MUL
        prev = result;
        dones = 0;
        op = 5'b10000; a = $urandom; b = $urandom; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", {63'b0, ready}, 64'd1);
        check("flush_result", {32'b0, result}, {32'b0, prev});
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("flush_dones", 64'(dones), 64'd0);

        // Reset in the middle of an iterative op
        dones = 0;
`ifdef OTTER_ALU_DIV_EN
        op = 5'b10101;
`else
        op = 5'b10000;
`endif
        a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_ready", {63'b0, ready}, 64'd1);
        check("mrst_result", {32'b0, result}, 64'd0);
        check("mrst_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("mrst_dones", 64'(dones), 64'd0);

        // Back-to-back: each following op is issued in the previous DONE cycle
        do_op(5'b00000, 32'd10, 32'd20, "b2b_a", 0);
        do_op(5'b01000, 32'd10, 32'd20, "b2b_b", 0);
        do_op(5'b10011, 32'hDEAD_BEEF, 32'h1234_5678, "b2b_c", 0);
`ifdef OTTER_ALU_DIV_EN
        do_op(5'b10100, 32'hFFFF_FF00, 32'd0, "b2b_d", 0);
        do_op(5'b10110, 32'hFFFF_FF00, 32'd7, "b2b_e", 0);
`else
        do_op(5'b10100, 32'd6, 32'd3, "b2b_d", 0);
        do_op(5'b00000, 32'd1, 32'd2, "b2b_e", 0);
`endif
        idle_check("b2b");

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 2) == 0) rop = {1'b0, 4'($urandom)};
            else rop = {1'b1, 4'($urandom)};
            do_op(rop, rand_opnd(), rand_opnd(), $sformatf("rnd%0d_op%0h", k, rop),
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
